// File: rtl/uart_mem_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader: frame constants
// and the state encodings used by the framing FSM and the byte receiver.
package uart_mem_loader_pkg;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        DATA,
        CHECK,
        DONE,
        ERR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_mem_loader_if.sv
// Instruction-memory write bus driven by the loader.
interface uart_mem_loader_if #(
    parameter int ADDR_W = 12
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchronises the line, confirms the start bit at
// half a bit time, samples data LSB-first at bit centres, then checks stop.
module uart_rx_byte
    import uart_mem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic          rxMeta_q;
    logic          rxSync_q;
    logic          rxPrev_q;
    rx_state_t     state_q;
    logic [CW-1:0] clkCnt_q;
    logic [2:0]    bitIdx_q;
    logic [7:0]    shift_q;
    logic [7:0]    byte_q;
    logic          valid_q;
    logic          frameErr_q;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= rx_i;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    // Bit-timing state machine; valid/frame_err are single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RX_IDLE;
            clkCnt_q   <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            frameErr_q <= 1'b0;
            unique case (state_q)
                RX_IDLE: begin
                    clkCnt_q <= '0;
                    if (rxPrev_q && !rxSync_q) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (clkCnt_q == HALF_LAST) begin
                        clkCnt_q <= '0;
                        bitIdx_q <= '0;
                        state_q  <= rxSync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        clkCnt_q <= clkCnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (clkCnt_q == BIT_LAST) begin
                        clkCnt_q <= '0;
                        shift_q  <= {rxSync_q, shift_q[7:1]};
                        bitIdx_q <= bitIdx_q + 3'd1;
                        if (bitIdx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (clkCnt_q == BIT_LAST) begin
                        clkCnt_q <= '0;
                        state_q  <= RX_IDLE;
                        if (rxSync_q) begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            frameErr_q <= 1'b1;
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + CW'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_o      = byte_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frameErr_q;

endmodule

// File: rtl/uart_mem_loader.sv
// Receives a framed program image over UART and writes it word by word into
// instruction memory, holding the core in reset while a frame is loading.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int ADDR_W       = 12,
    parameter int TIMEOUT_CYC  = 2**20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               uart_rx,
    uart_mem_loader_if.master  mem,
    output logic               core_rst_n,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [16:0]     MAX_WORDS    = 17'(1) << ADDR_W;
    localparam logic [ADDR_W:0] ONE_WORD     = (ADDR_W+1)'(1);

    logic [7:0]        rxByte;
    logic              rxValid;
    logic              rxFrameErr;

    loader_state_t     state_q;
    logic [7:0]        cntLo_q;
    logic [ADDR_W:0]   nWords_q;
    logic [ADDR_W:0]   wordCnt_q;
    logic [1:0]        byteIdx_q;
    logic [31:0]       wordBuf_q;
    logic [7:0]        xor_q;
    logic [TW-1:0]     timer_q;
    logic              memWe_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [31:0]       memWdata_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              coreRstN_q;

    logic [15:0]       nWords_d;
    logic              inFrame;

    assign nWords_d = {rxByte, cntLo_q};
    assign inFrame  = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                      (state_q == DATA)   || (state_q == CHECK);

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (uart_rx),
        .byte_o      (rxByte),
        .valid_o     (rxValid),
        .frame_err_o (rxFrameErr)
    );

    // Framing FSM: a received byte always wins over the idle timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cntLo_q    <= '0;
            nWords_q   <= '0;
            wordCnt_q  <= '0;
            byteIdx_q  <= '0;
            wordBuf_q  <= '0;
            xor_q      <= '0;
            timer_q    <= '0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            coreRstN_q <= 1'b1;
        end else begin
            memWe_q <= 1'b0;
            if (memWe_q) begin
                memAddr_q <= memAddr_q + ADDR_W'(1);
            end
            if (rxValid) begin
                timer_q <= '0;
                unique case (state_q)
                    IDLE, DONE, ERR: begin
                        if (rxByte == FRAME_HEADER) begin
                            state_q    <= CNT_LO;
                            done_q     <= 1'b0;
                            err_q      <= 1'b0;
                            busy_q     <= 1'b1;
                            coreRstN_q <= 1'b0;
                            memAddr_q  <= '0;
                            xor_q      <= '0;
                            wordCnt_q  <= '0;
                            byteIdx_q  <= '0;
                        end
                    end
                    CNT_LO: begin
                        cntLo_q <= rxByte;
                        state_q <= CNT_HI;
                    end
                    CNT_HI: begin
                        nWords_q <= nWords_d[ADDR_W:0];
                        if ({1'b0, nWords_d} > MAX_WORDS) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (nWords_d == 16'd0) begin
                            state_q <= CHECK;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        xor_q     <= xor_q ^ rxByte;
                        wordBuf_q <= {rxByte, wordBuf_q[31:8]};
                        byteIdx_q <= byteIdx_q + 2'd1;
                        if (byteIdx_q == 2'd3) begin
                            memWe_q    <= 1'b1;
                            memWdata_q <= {rxByte, wordBuf_q[31:8]};
                            wordCnt_q  <= wordCnt_q + ONE_WORD;
                            if (wordCnt_q + ONE_WORD == nWords_q) begin
                                state_q <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        busy_q <= 1'b0;
                        if (rxByte == xor_q) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            coreRstN_q <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (inFrame && (rxFrameErr || timer_q == TIMEOUT_LAST)) begin
                state_q <= ERR;
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                timer_q <= '0;
            end else if (inFrame) begin
                timer_q <= timer_q + TW'(1);
            end
        end
    end

    assign mem.mem_we    = memWe_q;
    assign mem.mem_addr  = memAddr_q;
    assign mem.mem_wdata = memWdata_q;
    assign core_rst_n    = coreRstN_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: frames are sent serially, expected
// memory writes are queued as each frame is issued, and a monitor process
// checks every mem_we pulse against the queue.
module tb_uart_mem_loader;

    localparam int CPB = 4;
    localparam int AW  = 4;
    localparam int TO  = 200;

    typedef logic [7:0] frame_t[$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic uart_rx;
    logic core_rst_n;
    logic busy;
    logic done;
    logic err;

    wr_t expQ[$];
    int  checksTotal  = 0;
    int  checksPassed = 0;
    logic prevWe = 1'b0;

    uart_mem_loader_if #(.ADDR_W(AW)) memIf ();

    uart_mem_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .mem        (memIf),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Single comparison point: every check bumps the counters here.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkStatus(input string tag, input logic b, input logic d, input logic e, input logic c);
        checkOutput({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
        checkOutput({tag, "_done"}, {31'd0, done}, {31'd0, d});
        checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, e});
        checkOutput({tag, "_core_rst_n"}, {31'd0, core_rst_n}, {31'd0, c});
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        uart_rx = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            waitCycles(CPB);
        end
        uart_rx = stopBit;
        waitCycles(CPB);
        uart_rx = 1'b1;
        waitCycles(3);
    endtask

    task automatic applyStimulus(input frame_t bytes);
        foreach (bytes[i]) begin
            sendByte(bytes[i], 1'b1);
        end
    endtask

    task automatic expectWrite(input logic [AW-1:0] a, input logic [31:0] d);
        expQ.push_back('{addr: a, data: d});
    endtask

    // Monitor: each write pulse is matched against the oldest expected write.
    always @(negedge clk) begin
        if (memIf.mem_we === 1'b1) begin
            if (expQ.size() == 0) begin
                checksTotal++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%08h, expected no write",
                         memIf.mem_addr, memIf.mem_wdata);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                checkOutput("write_addr", {{(32-AW){1'b0}}, memIf.mem_addr}, {{(32-AW){1'b0}}, e.addr});
                checkOutput("write_data", memIf.mem_wdata, e.data);
                checkOutput("write_single_pulse", {31'd0, prevWe}, 32'd0);
            end
        end
        prevWe = memIf.mem_we;
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed frame sequence.
    initial begin
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        waitCycles(5);
        checkStatus("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_mem_we", {31'd0, memIf.mem_we}, 32'd0);
        checkOutput("reset_mem_addr", {{(32-AW){1'b0}}, memIf.mem_addr}, 32'd0);
        rst_n = 1'b1;
        waitCycles(5);

        $display("[TB] two-word frame, checksum 13^93^10 = 90");
        expectWrite(4'd0, 32'h0000_0013);
        expectWrite(4'd1, 32'h0010_0093);
        applyStimulus('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                        8'h93, 8'h00, 8'h10, 8'h00, 8'h90});
        waitCycles(10);
        checkStatus("frameA", 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("frameA_pending", expQ.size(), 32'd0);

        $display("[TB] one-word frame with bad checksum");
        expectWrite(4'd0, 32'h0403_0201);
        applyStimulus('{8'hA5, 8'h01, 8'h00});
        checkStatus("frameB_mid", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus('{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF});
        waitCycles(10);
        checkStatus("frameB", 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("frameB_pending", expQ.size(), 32'd0);

        $display("[TB] zero-word frame and oversize count");
        applyStimulus('{8'hA5, 8'h00, 8'h00, 8'h00});
        waitCycles(10);
        checkStatus("zeroN", 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus('{8'hA5, 8'h11, 8'h00});
        waitCycles(10);
        checkStatus("bigN", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] inter-byte timeout");
        applyStimulus('{8'hA5, 8'h01, 8'h00, 8'hAA});
        waitCycles(100);
        checkStatus("timeout_early", 1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(150);
        checkStatus("timeout", 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus('{8'hA5, 8'h00, 8'h00, 8'h00});
        waitCycles(10);
        checkStatus("after_timeout", 1'b0, 1'b1, 1'b0, 1'b1);

        $display("[TB] framing error inside data");
        applyStimulus('{8'hA5, 8'h01, 8'h00});
        sendByte(8'h12, 1'b0);
        waitCycles(10);
        checkStatus("stop_err", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] one-cycle glitch before the checksum byte");
        applyStimulus('{8'hA5, 8'h00, 8'h00});
        uart_rx = 1'b0;
        waitCycles(1);
        uart_rx = 1'b1;
        waitCycles(60);
        checkStatus("glitch_mid", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus('{8'h00});
        waitCycles(10);
        checkStatus("glitch", 1'b0, 1'b1, 1'b0, 1'b1);

        $display("[TB] reset after two data bytes");
        applyStimulus('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00});
        checkStatus("prereset", 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkStatus("async_reset", 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("async_reset_mem_we", {31'd0, memIf.mem_we}, 32'd0);
        checkOutput("async_reset_mem_addr", {{(32-AW){1'b0}}, memIf.mem_addr}, 32'd0);
        checkOutput("async_reset_mem_wdata", memIf.mem_wdata, 32'd0);
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(3);
        applyStimulus('{8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90});
        waitCycles(10);
        checkStatus("post_reset", 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("final_pending", expQ.size(), 32'd0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
